// File: rtl/lsu_bus_if.sv
// Load/store unit bridging the core's memory instructions onto a valid/ready data bus.
// Handles byte lanes, load extension, misalignment faults and bus timeouts.
module lsu_bus_if #(
  parameter int unsigned TIMEOUT = 64
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  input  logic        is_store,
  input  logic [2:0]  mem_acc_mode,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic        stall,
  output logic        done,
  output logic [31:0] rdata,
  output logic        err,
  output logic        bus_req,
  output logic        bus_we,
  output logic [31:0] bus_addr,
  output logic [3:0]  bus_be,
  output logic [31:0] bus_wdata,
  input  logic        bus_gnt,
  input  logic        bus_rvalid,
  input  logic [31:0] bus_rdata
);

  localparam int unsigned CW = $clog2(TIMEOUT);
  localparam logic [CW-1:0] LAST = CW'(TIMEOUT - 1);

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT, S_DONE} state_t;

  state_t        r_state;
  logic [CW-1:0] r_cnt;
  logic [2:0]    r_mode;
  logic [1:0]    r_off;
  logic          r_done, r_err, r_req, r_we;
  logic [31:0]   r_addr, r_wdata, r_rdata;
  logic [3:0]    r_be;

  logic          w_fault;
  logic [3:0]    w_be;
  logic [31:0]   w_wdata, w_shift, w_ext;

  always_comb begin
    w_fault = (mem_acc_mode == 3'b011) || (mem_acc_mode[2:1] == 2'b11) ||
              ((mem_acc_mode[1:0] == 2'b01) && addr[0]) ||
              ((mem_acc_mode == 3'b010) && (addr[1:0] != 2'b00));
    case (mem_acc_mode[1:0])
      2'b00:   w_be = 4'b0001 << addr[1:0];
      2'b01:   w_be = 4'b0011 << addr[1:0];
      default: w_be = 4'b1111;
    endcase
    w_wdata = wdata << {addr[1:0], 3'b000};
    w_shift = bus_rdata >> {r_off, 3'b000};
    case (r_mode)
      3'b000:  w_ext = {{24{w_shift[7]}}, w_shift[7:0]};
      3'b001:  w_ext = {{16{w_shift[15]}}, w_shift[15:0]};
      3'b100:  w_ext = {24'h0, w_shift[7:0]};
      3'b101:  w_ext = {16'h0, w_shift[15:0]};
      default: w_ext = w_shift;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_mode  <= '0;
      r_off   <= '0;
      r_done  <= 1'b0;
      r_err   <= 1'b0;
      r_req   <= 1'b0;
      r_we    <= 1'b0;
      r_addr  <= '0;
      r_wdata <= '0;
      r_rdata <= '0;
      r_be    <= '0;
    end else begin
      r_done <= 1'b0;
      r_err  <= 1'b0;
      case (r_state)
        S_IDLE: if (req_valid) begin
          if (w_fault) begin
            r_done  <= 1'b1;
            r_err   <= 1'b1;
            r_state <= S_DONE;
          end else begin
            r_addr  <= {addr[31:2], 2'b00};
            r_be    <= w_be;
            r_wdata <= w_wdata;
            r_we    <= is_store;
            r_mode  <= mem_acc_mode;
            r_off   <= addr[1:0];
            r_req   <= 1'b1;
            r_cnt   <= '0;
            r_state <= S_REQ;
          end
        end
        S_REQ: begin
          // A load grant in the last budgeted cycle still aborts: no rvalid can fit.
          if (bus_gnt && r_we) begin
            r_req   <= 1'b0;
            r_done  <= 1'b1;
            r_state <= S_DONE;
          end else if (r_cnt == LAST) begin
            r_req   <= 1'b0;
            r_done  <= 1'b1;
            r_err   <= 1'b1;
            r_state <= S_DONE;
          end else begin
            r_cnt <= r_cnt + 1'b1;
            if (bus_gnt) begin
              r_req   <= 1'b0;
              r_state <= S_WAIT;
            end
          end
        end
        S_WAIT: begin
          if (bus_rvalid) begin
            r_rdata <= w_ext;
            r_done  <= 1'b1;
            r_state <= S_DONE;
          end else if (r_cnt == LAST) begin
            r_done  <= 1'b1;
            r_err   <= 1'b1;
            r_state <= S_DONE;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign stall     = req_valid & (r_state != S_DONE);
  assign done      = r_done;
  assign err       = r_err;
  assign rdata     = r_rdata;
  assign bus_req   = r_req;
  assign bus_we    = r_we;
  assign bus_addr  = r_addr;
  assign bus_be    = r_be;
  assign bus_wdata = r_wdata;

endmodule

// File: doc/lsu_bus_if.md
Name: lsu_bus_if

Overview:
- Load/store unit between the processor's ALU/address path and an external data-memory bus with a valid/ready handshake.
- Turns each load/store issued by the core into one word-aligned bus transaction, with byte enables and data lane shifting.
- Sign- or zero-extends load data.
- Stalls the core until the access completes, faults on misalignment, and times out on an unresponsive bus.

Parameters:
- TIMEOUT, 64, max cycles spent in REQ+WAIT before the access is aborted with err (≥2).

Ports:
- clk  in  1  system clock; all state updates on rising edge
- rst  in  1  synchronous, active-high reset
- req_valid  in  1  core has a memory instruction this cycle; held until done
- is_store  in  1  1 = store, 0 = load; valid with req_valid
- mem_acc_mode  in  3  funct3 encoding: 000 B, 001 H, 010 W, 100 BU, 101 HU; others illegal
- addr  in  32  byte address (ALU result)
- wdata  in  32  store data (rs2), in low-order bytes
- stall  out  1  freeze PC/register-file write while the access is in flight
- done  out  1  one-cycle pulse: access complete
- rdata  out  32  extended load data, valid when done=1 on a load
- err  out  1  with done: misaligned, illegal mode, or timeout
- bus_req  out  1  request valid
- bus_we  out  1  write enable
- bus_addr  out  32  word address, addr with bits [1:0] forced to 0
- bus_be  out  4  byte enables
- bus_wdata  out  32  lane-shifted store data
- bus_gnt  in  1  request accepted this cycle (ready)
- bus_rvalid  in  1  read data valid
- bus_rdata  in  32  read data word

Behaviour:
- Reset: state IDLE; stall, done, err, bus_req, bus_we = 0; bus_addr, bus_be, bus_wdata, rdata = 0; timeout counter = 0.
- rst asserted mid-transaction: return to IDLE next edge and drop bus_req. A late bus_gnt or bus_rvalid is ignored.
- stall = req_valid & (state != DONE). This is combinational, so it is asserted in the same cycle req_valid first rises.
- FSM states: IDLE, REQ, WAIT, DONE.
- IDLE, req_valid=1, address misaligned (H with addr[0]=1; W with addr[1:0]≠0) or mode illegal: go to DONE with err=1. No bus activity.
- IDLE, req_valid=1, legal: register bus_addr, bus_be, bus_wdata, bus_we, mode and addr[1:0]; go to REQ. bus_req rises the cycle after req_valid.
- Byte enables: B/BU → 0001<<addr[1:0]; H/HU → 0011<<addr[1:0]; W → 1111.
- Store data: bus_wdata = wdata << (8*addr[1:0]). Bytes outside the enables are don't-care.
- REQ: bus_req=1. bus_addr, bus_be, bus_wdata and bus_we stay stable until a cycle with bus_gnt=1.
  - On gnt for a store: go to DONE.
  - On gnt for a load: go to WAIT.
- bus_rvalid is only honoured in WAIT. It never arrives in the same cycle as gnt.
- WAIT: on bus_rvalid, shift = bus_rdata >> (8*addr[1:0]).
  - B: sign-extend shift[7:0]. BU: zero-extend shift[7:0].
  - H: sign-extend shift[15:0]. HU: zero-extend shift[15:0].
  - W: shift as-is.
  - Register the result into rdata and go to DONE.
- Timeout counter: cleared on leaving IDLE; increments each cycle in REQ or WAIT. When it reaches TIMEOUT-1 without completion: drop bus_req, go to DONE with err=1. rdata is unchanged.
- DONE: done=1 and stall=0 for exactly one cycle, then IDLE.
  - The core advances its PC on this edge. A new req_valid is sampled in IDLE the following cycle.
  - err is valid only while done=1.
- rdata holds its last value until the next successful load.
- Latency, gnt and rvalid both first-cycle: store = 3 cycles (IDLE, REQ, DONE); load = 4 cycles (IDLE, REQ, WAIT, DONE); fault = 2 cycles.

Test Plan:
- LW addr=0x100, bus_gnt in first REQ cycle, bus_rvalid=0xDEADBEEF next cycle → bus_addr=0x100, be=1111; done in the 4th cycle; rdata=0xDEADBEEF; err=0.
- LB addr=0x103, rdata word=0x80FF_0000 → be=1000; rdata=0xFFFFFF80. Same access as LBU → rdata=0x00000080.
- SH addr=0x202, wdata=0x0000ABCD, bus_gnt held low 3 cycles → bus_req/bus_addr=0x200/be=1100/bus_wdata[31:16]=0xABCD stable through the wait; done exactly one cycle after the gnt cycle.
- LW addr=0x101 → no bus_req ever; done=1, err=1 in the second cycle. Mode 011 gives the same result.
- TIMEOUT=8, LH addr=0x10 with bus_gnt never asserted → bus_req drops and done=1, err=1 after 8 REQ cycles; rdata unchanged.
- rst pulsed during WAIT, then bus_rvalid=1 → FSM in IDLE; no done; all outputs at reset values.
